dmem_upload_ctrl: RTL

Byte-stream loader that sequences UART-delivered program data into the data-memory upload port (upg_wen/upg_adr/upg_dat/upg_done). It parses a length-prefixed, checksummed frame from the UART receiver. It assembles little-endian 32-bit words and issues one-cycle write strobes at consecutive word addresses. It releases the memory back to the CPU via upg_done_o.

---
 rtl/dmem_upload_pkg.sv | 17 +
 rtl/dmem_upload_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dmem_upload_pkg.sv
// Shared types and frame constants for the UART-to-data-memory upload controller.
package dmem_upload_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int FRAME_LEN_BYTES = 2;
  localparam int BYTES_PER_WORD  = 4;

endpackage

// File: rtl/dmem_upload_ctrl.sv
// Parses a length-prefixed, XOR-checksummed byte frame and writes little-endian
// 32-bit words to consecutive data-memory addresses through the upload port.
module dmem_upload_ctrl
  import dmem_upload_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              load_done_o,
  output logic              err_o
);

  localparam int BIDX_W = $clog2(BYTES_PER_WORD);
  // One extra bit so a word count of exactly MAX_WORDS (== 2^ADDR_W) is representable.
  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] MAX_WORDS_C = CNT_W'(MAX_WORDS);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

  state_t              state_reg;
  logic [15:0]         len_reg;
  logic [CNT_W-1:0]    words_reg;
  logic [BIDX_W-1:0]   byte_idx_reg;
  logic [7:0]          csum_reg;
  logic [ADDR_W-1:0]   adr_reg;
  logic [31:0]         dat_reg;
  logic                err_reg;

  logic                accept;
  logic [15:0]         len_rx;
  logic [CNT_W-1:0]    words_next;

  assign accept     = rx_valid_i && rx_ready_o;
  assign len_rx     = {rx_data_i, len_reg[7:0]};
  assign words_next = words_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      words_reg    <= '0;
      byte_idx_reg <= '0;
      csum_reg     <= '0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg    <= LEN0;
            err_reg      <= 1'b0;
            adr_reg      <= '0;
            csum_reg     <= '0;
            words_reg    <= '0;
            byte_idx_reg <= '0;
          end
        end
        LEN0: begin
          if (accept) begin
            len_reg[7:0] <= rx_data_i;
            state_reg    <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            len_reg <= len_rx;
            if (len_rx == 16'd0) begin
              state_reg <= CSUM;
            end else if ({1'b0, len_rx} > MAX_WORDS_C) begin
              state_reg <= DONE;
              err_reg   <= 1'b1;
            end else begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            dat_reg[{byte_idx_reg, 3'b000} +: 8] <= rx_data_i;
            csum_reg     <= csum_reg ^ rx_data_i;
            byte_idx_reg <= byte_idx_reg + BIDX_W'(1);
            if (byte_idx_reg == LAST_BYTE) begin
              state_reg <= WRITE;
            end
          end
        end
        WRITE: begin
          // Address wraps naturally at 2^ADDR_W, which is where a full-size frame ends.
          adr_reg   <= adr_reg + ADDR_W'(1);
          words_reg <= words_next;
          if (words_next == {1'b0, len_reg}) begin
            state_reg <= CSUM;
          end else begin
            state_reg <= DATA;
          end
        end
        CSUM: begin
          if (accept) begin
            err_reg   <= (rx_data_i != csum_reg);
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rx_ready_o  = (state_reg == LEN0) || (state_reg == LEN1) ||
                       (state_reg == DATA) || (state_reg == CSUM);
  assign upg_wen_o   = (state_reg == WRITE);
  assign upg_done_o  = (state_reg == IDLE) || (state_reg == DONE);
  assign busy_o      = (state_reg != IDLE);
  assign load_done_o = (state_reg == DONE);
  assign upg_adr_o   = adr_reg;
  assign upg_dat_o   = dat_reg;
  assign err_o       = err_reg;

endmodule
